num_reg_loader: RTL

- Write-side companion to the numbotron 3-digit BCD register: loads a binary value (0..999) into the register through its existing inc/dec interface.
- Sequence per request: drain the register to zero with slow-clock-gated decrements, convert the binary value to BCD by iterative double-dabble, then emit per-digit direct increment pulses.
- Sits between the controller and one register instance. While busy it is the register's only driver of inc/dec.

---
 rtl/num_reg_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/num_reg_loader.sv
// Loads a binary value (0..999) into a 3-digit BCD register through its inc/dec port.
// The register is drained to zero first, then the value is converted to BCD and replayed digit by digit.
module num_reg_loader #(
  parameter int VAL_W     = 10,
  parameter int PULSE_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slowclk,
  input  logic             start,
  input  logic [VAL_W-1:0] load_val,
  input  logic             reg_z,
  output logic             reg_dec,
  output logic [2:0]       reg_inc_dig,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state   | meaning
  // IDLE    | waiting for start
  // CLEAR   | decrementing the register on slowclk strobes until it reads 000
  // CONV    | VAL_W cycles of double-dabble, binary -> BCD
  // LOAD    | per-digit increment pulses (units, tens, hundreds), optional gaps
  // DONE    | one-cycle completion pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [VAL_W-1:0] MAX_VAL   = VAL_W'(999);
  localparam logic [3:0]       CONV_LAST = 4'(VAL_W - 1);
  localparam logic [2:0]       GAP       = 3'(PULSE_GAP);

  logic [2:0]       r_state;
  logic [VAL_W-1:0] r_shift;
  logic [11:0]      r_bcd;
  logic [3:0]       r_conv_cnt;
  logic [2:0]       r_gap_cnt;
  logic             r_err;

  logic [11:0] w_adj;
  logic [11:0] w_dd_next;
  logic [2:0]  w_sel;
  logic [11:0] w_bcd_dec;
  logic        w_pulse;

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary MSB.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_dd_next = 12'({w_adj, r_shift[VAL_W-1]});
  end

  // Lowest non-zero digit is the one being replayed; zero digits are skipped without a bubble.
  always_comb begin
    w_sel = 3'b000;
    if (r_bcd[3:0] != 4'd0)       w_sel = 3'b001;
    else if (r_bcd[7:4] != 4'd0)  w_sel = 3'b010;
    else if (r_bcd[11:8] != 4'd0) w_sel = 3'b100;
  end

  always_comb begin
    w_bcd_dec = r_bcd;
    if (w_sel[0])      w_bcd_dec[3:0]  = r_bcd[3:0]  - 4'd1;
    else if (w_sel[1]) w_bcd_dec[7:4]  = r_bcd[7:4]  - 4'd1;
    else if (w_sel[2]) w_bcd_dec[11:8] = r_bcd[11:8] - 4'd1;
  end

  assign w_pulse     = (r_state == S_LOAD) && (r_gap_cnt == 3'd0);
  assign reg_inc_dig = w_pulse ? w_sel : 3'b000;
  assign reg_dec     = (r_state == S_CLEAR);
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_conv_cnt <= '0;
      r_gap_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err      <= 1'b0;
            r_shift    <= load_val;
            r_bcd      <= '0;
            r_conv_cnt <= CONV_LAST;
            r_gap_cnt  <= '0;
            if (load_val > MAX_VAL) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (reg_z) begin
              r_state <= S_CONV;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          // reg_z is look-ahead: this strobe's decrement lands on 000, so stop here.
          if (slowclk && reg_z)
            r_state <= S_CONV;
        end
        S_CONV: begin
          r_bcd   <= w_dd_next;
          r_shift <= r_shift << 1;
          if (r_conv_cnt == 4'd0)
            r_state <= (w_dd_next == 12'd0) ? S_DONE : S_LOAD;
          else
            r_conv_cnt <= r_conv_cnt - 4'd1;
        end
        S_LOAD: begin
          if (r_gap_cnt != 3'd0) begin
            r_gap_cnt <= r_gap_cnt - 3'd1;
            if (r_gap_cnt == 3'd1 && r_bcd == 12'd0)
              r_state <= S_DONE;
          end else begin
            r_bcd     <= w_bcd_dec;
            r_gap_cnt <= GAP;
            if (GAP == 3'd0 && w_bcd_dec == 12'd0)
              r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
